fpmul_arbiter: RTL and testbench
================================

# fpmul_arbiter

Shares one fixed-latency floating-point multiplier (unpack, multiply, normalize, round) between NREQ requesters, such as FIR tap lanes. Each cycle it grants at most one requester through a valid/ready handshake, registers the operands into the multiplier, and tracks each in-flight operation's owner in a tag pipeline. Each result goes back only to the requester that issued it. The block sits between the FIR tap controllers and the multiplier datapath.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `WIDTH`, 32: operand and result width (IEEE single).
- `LAT`, 3: multiplier latency, in cycles from `mul_start` to `mul_result` valid (1..8).
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `hold` in 1: blocks new grants; in-flight operations still drain.
- `req_valid` in NREQ: per-requester operand valid.
- `req_a` in NREQ*WIDTH: packed operand A; requester i uses `[i*WIDTH +: WIDTH]`.
- `req_b` in NREQ*WIDTH: packed operand B, same packing.
- `req_ready` out NREQ: one-hot (or zero) grant.
- `mul_start` out 1: operands presented to the multiplier this cycle.
- `mul_a`, `mul_b` out WIDTH: registered operands.
- `mul_result` in WIDTH: multiplier output, valid LAT cycles after `mul_start`.
- `rsp_valid` out NREQ: one-hot; the result belongs to that requester.
- `rsp_result` out WIDTH: equal to `mul_result`.
- `busy` out 1: at least one operation is in flight.

## Operation
- Grant: `req_ready[i]` = `~hold & ~reset & (i == winner)`, where the winner is the first requester with `req_valid` set, searching from `rr_ptr` upward and wrapping.
- A transfer happens when `req_valid[i] & req_ready[i]`. At most one transfer per cycle.
- On a transfer:
  - Next cycle, `mul_start`=1 and `mul_a`/`mul_b` hold requester i's operands.
  - Next cycle, a tag pipeline entry {valid=1, id=i} enters stage 0.
  - `rr_ptr` becomes (i+1) mod NREQ.
- With no transfer, `mul_start`=0 and `rr_ptr` is unchanged. `mul_a`/`mul_b` keep their last values.
- Tag pipeline: LAT stages that shift every cycle. `rsp_valid` is the one-hot decode of the last stage's id, gated by its valid bit.
- `busy` = OR of all tag valid bits OR `mul_start`.
- A requester may drop `req_valid` without a transfer; no state changes.
- `hold` asserted with all requesters valid: no grants, and the pipeline drains normally.
- Reset mid-operation:
  - Tag pipeline valid bits clear, `rr_ptr`=0 and `mul_start`=0.
  - Results from operations issued before reset are discarded: `rsp_valid` stays 0 even though `mul_result` may still change.
  - No grant is given during the reset cycle.

## Timing
- Reset values: `req_ready`=0 while reset is high, `mul_start`=0, `mul_a`=`mul_b`=0, `rsp_valid`=0, `rsp_result` follows its input, `busy`=0, `rr_ptr`=0.
- `req_ready` is combinational from `req_valid`, `hold` and `rr_ptr`. It has no dependence on `req_a` or `req_b`.
- Latency: handshake in cycle T gives `mul_start` in T+1 and `rsp_valid` in T+1+LAT.
- Throughput is one operation per cycle, full pipelining.
- `rsp_valid` is registered-path only, with no combinational path from `req_*`.

## Configuration
- `FPMUL_ARB_FIXED_PRI_EN` defined: fixed priority, lowest index wins. The `rr_ptr` register and its update logic are removed.
- Undefined (default): round-robin as described under Operation.

## Structure
- The shared constants include (alongside the existing multiplier constants) holds:
  - the default `WIDTH` and `LAT`;
  - the tag-width function ceil(log2(NREQ)), with minimum 1.
- Sub-module `fpmul_rr_pick`: purely combinational. Takes `req_valid` and `rr_ptr`, returns a one-hot winner and its encoded id. The fixed-priority build drives `ptr`=0.
- Everything else lives in `fpmul_arbiter`: operand registers, tag pipeline, pointer and busy logic.

## Test plan
- Single request: NREQ=4, LAT=3, req1 valid with a=0x3FC00000, b=0x40000000 in cycle 5.
  - `req_ready`=0010 in cycle 5 and `mul_start` in cycle 6.
  - Model result 0x40400000 with `rsp_valid`=0010 in cycle 9.
- Round-robin fairness: all four valid continuously.
  - Grants are 0,1,2,3,0,… in consecutive cycles.
  - `rsp_valid` shows the same order starting LAT+1 cycles later.
  - With `FPMUL_ARB_FIXED_PRI_EN`, requester 0 wins every cycle.
- Wrap and skip: ptr=3, only req0 and req2 valid.
  - Req0 is granted, then req2, then req0.
- Hold: hold=1 for 5 cycles with all requests valid.
  - `req_ready`=0 throughout and in-flight results still return.
  - `busy` falls LAT+1 cycles after the last grant.
- Reset mid-flight: grant req2 in cycle 10, reset high in cycle 12.
  - `rsp_valid` stays 0 in cycle 14 and `busy`=0 in cycle 13.
  - The first grant after reset goes to the lowest valid requester at or above 0.
- Back-to-back throughput: 16 transfers in 16 consecutive cycles.
  - 16 consecutive `rsp_valid` pulses, each with the correct owner and product.

Source files
------------

// File: rtl/fpmul_arbiter_pkg.sv
// Shared constants for the shared floating-point multiplier and its arbiter.
// Build option: FPMUL_ARB_FIXED_PRI_EN selects fixed priority in fpmul_arbiter.
package fpmul_arbiter_pkg;

   // IEEE single-precision field layout used by the multiplier datapath
   localparam int FP_EXP_W = 8;
   localparam int FP_MAN_W = 23;
   localparam int FP_BIAS  = 127;

   // Arbiter defaults: one IEEE single per operand, three-cycle multiplier
   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_LAT   = 3;

   // Bits needed to name one of n requesters; never narrower than one bit
   function automatic int tag_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/fpmul_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr,
// wrapping past the top index. Driving ptr to zero gives lowest-index priority.
module fpmul_rr_pick
   import fpmul_arbiter_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int TAG_W = tag_width(NREQ)
) (
   input  logic [NREQ-1:0]  valid,
   input  logic [TAG_W-1:0] ptr,
   output logic [NREQ-1:0]  grant,
   output logic [TAG_W-1:0] id,
   output logic             any
);

   int idx;

   // Walk the requesters starting at ptr; the first valid one wins
   always_comb begin
      grant = '0;
      id    = '0;
      any   = 1'b0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!any && valid[idx]) begin
            any        = 1'b1;
            grant[idx] = 1'b1;
            id         = TAG_W'(idx);
         end
      end
   end

endmodule

// File: rtl/fpmul_arbiter.sv
// Shares one fixed-latency FP multiplier between NREQ requesters. One grant per
// cycle, operands registered into the multiplier, and a tag pipeline that routes
// each result back to its issuer.
// Build option: FPMUL_ARB_FIXED_PRI_EN -> lowest index always wins, no rr pointer.
module fpmul_arbiter
   import fpmul_arbiter_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int LAT   = DEFAULT_LAT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  hold,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [NREQ-1:0]       req_ready,
   output logic                  mul_start,
   output logic [WIDTH-1:0]      mul_a,
   output logic [WIDTH-1:0]      mul_b,
   input  logic [WIDTH-1:0]      mul_result,
   output logic [NREQ-1:0]       rsp_valid,
   output logic [WIDTH-1:0]      rsp_result,
   output logic                  busy
);

   localparam int TAG_W = tag_width(NREQ);

   logic [NREQ-1:0]  win_grant;
   logic [TAG_W-1:0] win_id;
   logic             win_any;
   logic [TAG_W-1:0] pick_ptr;
   logic             xfer;

   logic [LAT-1:0]   tag_valid;
   logic [TAG_W-1:0] tag_id [LAT];

`ifdef FPMUL_ARB_FIXED_PRI_EN
   assign pick_ptr = '0;
`else
   logic [TAG_W-1:0] rr_ptr;

   // Pointer moves just past the requester that was served
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr <= '0;
      end else if (xfer) begin
         rr_ptr <= (win_id == TAG_W'(NREQ - 1)) ? '0 : win_id + TAG_W'(1);
      end
   end

   assign pick_ptr = rr_ptr;
`endif

   fpmul_rr_pick #(
      .NREQ  (NREQ),
      .TAG_W (TAG_W)
   ) u_pick (
      .valid (req_valid),
      .ptr   (pick_ptr),
      .grant (win_grant),
      .id    (win_id),
      .any   (win_any)
   );

   assign req_ready = (hold || reset) ? '0 : win_grant;
   assign xfer      = win_any && !hold && !reset;

   // Capture the winner's operands and launch the multiplier the next cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         mul_start <= 1'b0;
         mul_a     <= '0;
         mul_b     <= '0;
      end else begin
         mul_start <= xfer;
         if (xfer) begin
            mul_a <= req_a[win_id*WIDTH +: WIDTH];
            mul_b <= req_b[win_id*WIDTH +: WIDTH];
         end
      end
   end

   // Tag valid bits travel alongside the multiplier; reset drops anything in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_valid <= '0;
      end else begin
         tag_valid[0] <= xfer;
         for (int s = 1; s < LAT; s++) tag_valid[s] <= tag_valid[s-1];
      end
   end

   // Owner ids shift with their valid bits; stale ids are harmless once invalid
   always_ff @(posedge clk) begin
      tag_id[0] <= win_id;
      for (int s = 1; s < LAT; s++) tag_id[s] <= tag_id[s-1];
   end

   // Registered one-hot decode of the oldest tag lines up with mul_result
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid <= '0;
      end else if (tag_valid[LAT-1]) begin
         rsp_valid <= NREQ'(1) << tag_id[LAT-1];
      end else begin
         rsp_valid <= '0;
      end
   end

   assign rsp_result = mul_result;
   assign busy       = (|tag_valid) || mul_start;

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Bench for fpmul_arbiter: table of grant vectors, hand-written multi-cycle
// sequences, a behavioural multiplier and a response scoreboard.
// Honours FPMUL_ARB_FIXED_PRI_EN for expected grants.
module tb_fpmul_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 32;
   localparam int LAT   = 3;

   logic                  clk;
   logic                  reset;
   logic                  hold;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ-1:0]       req_ready;
   logic                  mul_start;
   logic [WIDTH-1:0]      mul_a;
   logic [WIDTH-1:0]      mul_b;
   logic [WIDTH-1:0]      mul_result;
   logic [NREQ-1:0]       rsp_valid;
   logic [WIDTH-1:0]      rsp_result;
   logic                  busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int rsp_count = 0;

   typedef struct {
      int          id;
      logic [31:0] res;
      int          due;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      logic [NREQ-1:0] valid;
      logic            hold;
      logic [NREQ-1:0] ready;
   } vec_t;
   vec_t vecs[14];

   logic [31:0] mpipe [LAT];

   fpmul_arbiter #(
      .NREQ  (NREQ),
      .WIDTH (WIDTH),
      .LAT   (LAT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .hold       (hold),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .mul_start  (mul_start),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_result (mul_result),
      .rsp_valid  (rsp_valid),
      .rsp_result (rsp_result),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Reference IEEE single multiply for normal operands, round to nearest even
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic        sign;
      logic [47:0] p;
      logic [22:0] mant;
      logic [23:0] m;
      logic        guard;
      logic        sticky;
      int          e;
      sign = a[31] ^ b[31];
      if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {sign, 31'd0};
      p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (p[47]) begin
         mant = p[46:24]; guard = p[23]; sticky = |p[22:0]; e = e + 1;
      end else begin
         mant = p[45:23]; guard = p[22]; sticky = |p[21:0];
      end
      m = {1'b0, mant};
      if (guard && (sticky || mant[0])) m = m + 24'd1;
      if (m[23]) e = e + 1;
      return {sign, e[7:0], m[22:0]};
   endfunction

   function automatic logic [31:0] rand_fp();
      logic [7:0] ex;
      ex = 8'($urandom_range(110, 144));
      return {1'($urandom_range(0, 1)), ex, 23'($urandom)};
   endfunction

   // Expected grant: table value for round robin, lowest valid index otherwise
   function automatic logic [NREQ-1:0] exp_ready(input logic [NREQ-1:0] rr,
                                                 input logic [NREQ-1:0] v,
                                                 input logic h);
`ifdef FPMUL_ARB_FIXED_PRI_EN
      if (h) return '0;
      return v & (~v + NREQ'(1));
`else
      if (h && v == '1) return rr;
      return rr;
`endif
   endfunction

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic randomize_operands();
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*WIDTH +: WIDTH] = rand_fp();
         req_b[i*WIDTH +: WIDTH] = rand_fp();
      end
   endtask

   task automatic apply_stimulus(input logic [NREQ-1:0] v, input logic h);
      @(posedge clk);
      #1;
      req_valid = v;
      hold      = h;
      randomize_operands();
   endtask

   // Behavioural multiplier: LAT-cycle pipeline fed from the registered operands
   always @(posedge clk) begin
      mpipe[0] <= mul_start ? fmul(mul_a, mul_b) : 32'hDEAD_BEEF;
      for (int s = 1; s < LAT; s++) mpipe[s] <= mpipe[s-1];
   end
   assign mul_result = mpipe[LAT-1];

   // Scoreboard: push on handshake, pop and compare on each response pulse
   always @(negedge clk) begin
      exp_t e;
      if (rsp_valid != '0) begin
         rsp_count++;
         if (sbq.size() == 0) begin
            check_output("rsp_unexpected", 64'(rsp_valid), 64'd0);
         end else begin
            e = sbq.pop_front();
            check_output("rsp_owner",  64'(rsp_valid),  64'(NREQ'(1) << e.id));
            check_output("rsp_result", 64'(rsp_result), 64'(e.res));
            check_output("rsp_cycle",  64'(cyc),        64'(e.due));
         end
      end
      if (reset) begin
         sbq.delete();
      end else if ((req_valid & req_ready) != '0) begin
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               e.id  = i;
               e.res = fmul(req_a[i*WIDTH +: WIDTH], req_b[i*WIDTH +: WIDTH]);
               e.due = cyc + 1 + LAT;
               sbq.push_back(e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base;
      int ptr;
      vecs[0]  = '{4'b1111, 1'b0, 4'b0001};
      vecs[1]  = '{4'b1111, 1'b0, 4'b0010};
      vecs[2]  = '{4'b1111, 1'b0, 4'b0100};
      vecs[3]  = '{4'b1111, 1'b0, 4'b1000};
      vecs[4]  = '{4'b1111, 1'b0, 4'b0001};
      vecs[5]  = '{4'b0001, 1'b0, 4'b0001};
      vecs[6]  = '{4'b1000, 1'b0, 4'b1000};
      vecs[7]  = '{4'b0100, 1'b0, 4'b0100};
      vecs[8]  = '{4'b0101, 1'b0, 4'b0001};
      vecs[9]  = '{4'b0101, 1'b0, 4'b0100};
      vecs[10] = '{4'b0101, 1'b0, 4'b0001};
      vecs[11] = '{4'b1111, 1'b1, 4'b0000};
      vecs[12] = '{4'b0000, 1'b0, 4'b0000};
      vecs[13] = '{4'b0110, 1'b0, 4'b0010};

      reset     = 1'b1;
      hold      = 1'b0;
      req_valid = '1;
      req_a     = '0;
      req_b     = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_output("reset_ready",     64'(req_ready), 64'd0);
      check_output("reset_mul_start", 64'(mul_start), 64'd0);
      check_output("reset_mul_a",     64'(mul_a),     64'd0);
      check_output("reset_mul_b",     64'(mul_b),     64'd0);
      check_output("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      check_output("reset_busy",      64'(busy),      64'd0);
      @(posedge clk);
      #1;
      reset     = 1'b0;
      req_valid = '0;

      // Grant table, starting from pointer 0
      for (int r = 0; r < 14; r++) begin
         apply_stimulus(vecs[r].valid, vecs[r].hold);
         @(negedge clk);
         check_output($sformatf("grant_vec%0d", r), 64'(req_ready),
                      64'(exp_ready(vecs[r].ready, vecs[r].valid, vecs[r].hold)));
      end
      apply_stimulus('0, 1'b0);
      repeat (LAT + 2) @(posedge clk);

      // Single request with known operands
      @(posedge clk);
      #1;
      req_valid = 4'b0010;
      req_a[1*WIDTH +: WIDTH] = 32'h3FC0_0000;
      req_b[1*WIDTH +: WIDTH] = 32'h4000_0000;
      @(negedge clk);
      check_output("single_ready", 64'(req_ready), 64'(4'b0010));
      @(posedge clk);
      #1;
      req_valid = '0;
      @(negedge clk);
      check_output("single_mul_start", 64'(mul_start), 64'd1);
      check_output("single_mul_a",     64'(mul_a),     64'h3FC0_0000);
      check_output("single_mul_b",     64'(mul_b),     64'h4000_0000);
      repeat (LAT) @(posedge clk);
      @(negedge clk);
      check_output("single_rsp_valid",  64'(rsp_valid),  64'(4'b0010));
      check_output("single_rsp_result", 64'(rsp_result), 64'h4040_0000);

      // Hold with every requester valid; pipeline drains
      apply_stimulus('1, 1'b0);
      apply_stimulus('1, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         apply_stimulus('1, 1'b1);
         @(negedge clk);
         check_output($sformatf("hold_ready%0d", k), 64'(req_ready), 64'd0);
         if (k == LAT)     check_output("hold_busy_high", 64'(busy), 64'd1);
         if (k == LAT + 1) check_output("hold_busy_low",  64'(busy), 64'd0);
      end
      apply_stimulus('0, 1'b0);
      repeat (LAT + 2) @(posedge clk);

      // Reset while an operation from requester 2 is in flight
      apply_stimulus(4'b0100, 1'b0);
      @(negedge clk);
      check_output("rst_grant2", 64'(req_ready), 64'(4'b0100));
      apply_stimulus('0, 1'b0);
      @(posedge clk);
      #1;
      reset     = 1'b1;
      req_valid = '1;
      @(negedge clk);
      check_output("rst_cycle_ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1;
      reset     = 1'b0;
      req_valid = 4'b1110;
      @(negedge clk);
      check_output("rst_busy",        64'(busy),      64'd0);
      check_output("rst_first_grant", 64'(req_ready), 64'(4'b0010));
      apply_stimulus('0, 1'b0);
      @(negedge clk);
      check_output("rst_rsp_discard", 64'(rsp_valid), 64'd0);
      repeat (LAT + 2) @(posedge clk);

      // Sixteen back-to-back transfers; pointer sits just past requester 1
      base = rsp_count;
      ptr  = 2;
      for (int k = 0; k < 16; k++) begin
         apply_stimulus('1, 1'b0);
         @(negedge clk);
`ifdef FPMUL_ARB_FIXED_PRI_EN
         check_output($sformatf("b2b_grant%0d", k), 64'(req_ready), 64'(4'b0001));
`else
         check_output($sformatf("b2b_grant%0d", k), 64'(req_ready), 64'(NREQ'(1) << ((ptr + k) % NREQ)));
`endif
      end
      apply_stimulus('0, 1'b0);
      repeat (LAT + 3) @(posedge clk);
      @(negedge clk);
      check_output("b2b_rsp_count", 64'(rsp_count - base), 64'd16);
      check_output("drain_queue",   64'(sbq.size()),        64'd0);
      check_output("drain_busy",    64'(busy),              64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
